aging_priority_arbiter: RTL

- Registered N-way arbiter. Base policy is fixed priority: index 0 is highest.
- Adds multi-cycle grant hold, a bounded tenure (HOLD_MAX) and age-based starvation promotion. Low-priority requesters are therefore guaranteed service.
- Sits in front of a single shared resource (bus or port) in place of the combinational fixed-priority arbiter. The resource's owner is taken from grant / grant_id.

---
 rtl/aging_priority_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/aging_priority_arbiter.sv
// Registered fixed-priority arbiter with bounded grant tenure and age-based
// starvation promotion; index 0 has the highest base priority.
module aging_priority_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned AGE_LIMIT = 8,
  parameter int unsigned HOLD_MAX  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N-1:0]                       req,
  output logic [N-1:0]                       grant,
  output logic                               grant_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id,
  output logic                               promoted
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);
  localparam int unsigned HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] id_q, id_d;
  logic          prom_q, prom_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [AW-1:0] age_q [N];
  logic [AW-1:0] age_d [N];

  logic          busy, rel, arb;
  logic [N-1:0]  others, cand, starving;
  logic [IW-1:0] cand_idx, starv_idx, winner_idx;

  always_comb begin
    busy = |grant_q;
    rel  = busy && (!(|(req & grant_q)) || (hold_q == HW'(HOLD_MAX - 1)));
    arb  = !busy || rel;

    // An expiring owner yields only if someone else is waiting.
    others = req & ~grant_q;
    cand   = (rel && (|others)) ? others : req;

    for (int i = 0; i < int'(N); i++) begin
      starving[i] = cand[i] && (age_q[i] == AW'(AGE_LIMIT));
    end

    cand_idx  = '0;
    starv_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (cand[i])     cand_idx  = IW'(i);
      if (starving[i]) starv_idx = IW'(i);
    end
    winner_idx = (|starving) ? starv_idx : cand_idx;

    grant_d = grant_q;
    id_d    = id_q;
    prom_d  = prom_q;
    hold_d  = hold_q + 1'b1;
    if (arb) begin
      hold_d = '0;
      if (|cand) begin
        grant_d             = '0;
        grant_d[winner_idx] = 1'b1;
        id_d                = winner_idx;
        prom_d              = (|starving) && (winner_idx != cand_idx);
      end else begin
        grant_d = '0;
        id_d    = '0;
        prom_d  = 1'b0;
      end
    end

    for (int i = 0; i < int'(N); i++) begin
      if (req[i] && !grant_q[i]) begin
        age_d[i] = (age_q[i] == AW'(AGE_LIMIT)) ? age_q[i] : age_q[i] + 1'b1;
      end else begin
        age_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      id_q    <= '0;
      prom_q  <= 1'b0;
      hold_q  <= '0;
      for (int i = 0; i < int'(N); i++) age_q[i] <= '0;
    end else begin
      grant_q <= grant_d;
      id_q    <= id_d;
      prom_q  <= prom_d;
      hold_q  <= hold_d;
      for (int i = 0; i < int'(N); i++) age_q[i] <= age_d[i];
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = id_q;
  assign promoted    = prom_q;

endmodule
